move_validator: RTL and testbench
=================================

MOVE_VALIDATOR -- requirements
Module: move_validator

Interface
REQ-001 The module SHALL have parameter BOARD_W, default 10, meaning the row stride of the walled 10x10 board memory.
REQ-002 The module SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port start, input, 1, a validation request, sampled only in IDLE.
REQ-005 The module SHALL have port s_addr_in, input, 7, the candidate square address (row*BOARD_W+col), latched on start.
REQ-006 The module SHALL have port player, input, 1 (0 black, 1 white), latched on start.
REQ-007 The module SHALL have port rd_addr, output, 7, the board-memory read address.
REQ-008 The module SHALL have port rd_data, input, 2, the cell code, valid one cycle after rd_addr is presented.
REQ-009 The module SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-010 The module SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 The module SHALL have port mv_valid, output, 1, equal to the OR of dir_mask.
REQ-012 The module SHALL have port dir_mask, output, 8, the flippable-direction flags; bit i corresponds to offset i of {-11,-10,-9,-1,+1,+9,+10,+11}.

Function
REQ-013 Cell codes SHALL be: 00 empty, 01 black, 10 white, 11 wall; own = player?10:01, opponent = the other colour.
REQ-014 The FSM SHALL have the states IDLE, ISSUE, CHECK and DONE; each memory read SHALL take one ISSUE cycle (rd_addr = pointer) followed by one CHECK cycle (rd_data evaluated).
REQ-015 In IDLE with start=1, the block SHALL latch s_addr_in and player, set pointer=s_addr_in, clear dir_mask and the direction index, and go to ISSUE.
REQ-016 Self check: a non-empty cell at s_addr (including wall) SHALL go to DONE with dir_mask=0; an empty cell SHALL start direction 0 at s_addr+offset0.
REQ-017 Direction scan: in CHECK, opponent SHALL set seen_opp and advance pointer by the offset (to ISSUE).
REQ-018 Direction scan: own with seen_opp SHALL set dir_mask[i] and end the direction.
REQ-019 Direction scan: own without seen_opp, empty, or wall SHALL end the direction with bit i clear.
REQ-020 Ending a direction SHALL clear seen_opp and increment i; after i=7, the next state SHALL be DONE; otherwise pointer SHALL be set to s_addr+offset(i+1) and the next state ISSUE.
REQ-021 All directions SHALL be scanned; there SHALL be no early exit after the first valid direction.
REQ-022 Address arithmetic SHALL be 7-bit unsigned modulo 128; wall cells guarantee termination before wrap on a legal board.
REQ-023 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 Latency SHALL be exactly 2R+1 cycles from the start-sampling edge to done high, where R is the number of reads.
REQ-025 dir_mask and mv_valid SHALL hold their values from DONE until the next accepted start.
REQ-026 start asserted while busy or in DONE SHALL be ignored.
REQ-027 rd_addr SHALL be 0 in IDLE and DONE.

Reset
REQ-028 On reset low, the FSM SHALL go to IDLE asynchronously, clearing busy=0, done=0, mv_valid=0, dir_mask=0, rd_addr=0, pointer, seen_opp and the latched inputs.
REQ-029 A reset asserted mid-scan SHALL abort the scan with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-030 Cell codes, BOARD_W, the direction-offset table and the FSM state encoding SHALL reside in the shared package othello_pkg, which is also used by the datapath.
REQ-031 No sub-module SHALL be used; the design SHALL be a single FSM plus pointer, index and mask registers.

Verification
REQ-032 The bench SHALL use a 1-cycle-latency board model with walls at row/col 0 and 9, and the initial position 44=W, 55=W, 45=B, 54=B.
REQ-033 Scenario: start, s_addr=34, player=0 -> R=10, done at cycle 21, dir_mask=0x40, mv_valid=1.
REQ-034 Scenario: start, s_addr=44 (occupied) -> R=1, done at cycle 3, dir_mask=0x00, mv_valid=0.
REQ-035 Scenario: start, s_addr=10 (wall) -> done at cycle 3, mv_valid=0; start, s_addr=33, player=0 -> done with dir_mask=0x00 (diagonal 44 W then 55 W then 66 empty).
REQ-036 Scenario: row 1 set as 12..17=W and 18=B, start, s_addr=11, player=0 -> dir_mask=0x10 with the +1 scan reading through to 18.
REQ-037 Scenario: start pulsed during a scan -> no restart and results unchanged.
REQ-038 Scenario: reset pulsed mid-scan -> all outputs 0 and no done; a fresh start to 34 -> 0x40 as in REQ-033.

Source files
------------

// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell codes, board geometry, direction offsets and
// the validator FSM state encoding.
package othello_pkg;

   // Row stride of the walled 10x10 board memory.
   localparam int unsigned BOARD_W = 10;
   // Board-memory address width; all square arithmetic wraps modulo 2**ADDR_W.
   localparam int unsigned ADDR_W  = 7;
   localparam int unsigned NUM_DIR = 8;

   typedef enum logic [1:0] {
      CellEmpty = 2'b00,
      CellBlack = 2'b01,
      CellWhite = 2'b10,
      CellWall  = 2'b11
   } cell_t;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StIssue = 2'b01,
      StCheck = 2'b10,
      StDone  = 2'b11
   } state_t;

   // Offset table {-(W+1), -W, -(W-1), -1, +1, W-1, W, W+1} as 7-bit two's complement.
   function automatic logic [ADDR_W-1:0] dir_offset(input int unsigned bw,
                                                    input logic [2:0] idx);
      logic [ADDR_W-1:0] w;
      logic [ADDR_W-1:0] off;
      w = ADDR_W'(bw);
      unique case (idx)
         3'd0:    off = 7'd0 - w - 7'd1;
         3'd1:    off = 7'd0 - w;
         3'd2:    off = 7'd0 - w + 7'd1;
         3'd3:    off = 7'h7f;
         3'd4:    off = 7'd1;
         3'd5:    off = w - 7'd1;
         3'd6:    off = w;
         default: off = w + 7'd1;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/move_validator.sv
// Othello move validator: checks whether a candidate square is empty and, for
// each of the eight directions, whether a run of opponent discs is capped by
// one of the mover's own discs. One board read per ISSUE/CHECK cycle pair.
module move_validator #(
   parameter int unsigned BOARD_W = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] s_addr_in,
   input  logic       player,
   output logic [6:0] rd_addr,
   input  logic [1:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       mv_valid,
   output logic [7:0] dir_mask
);

   import othello_pkg::*;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]   saddr_q, saddr_d;
   logic                player_q, player_d;
   logic [2:0]          idx_q, idx_d;
   logic                seen_q, seen_d;
   logic                self_q, self_d;
   logic [NUM_DIR-1:0]  mask_q, mask_d;

   cell_t               own, opp;
   logic                end_dir;

   // State, datapath and latched-request registers; reset aborts any scan.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         saddr_q  <= '0;
         player_q <= 1'b0;
         idx_q    <= '0;
         seen_q   <= 1'b0;
         self_q   <= 1'b0;
         mask_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         saddr_q  <= saddr_d;
         player_q <= player_d;
         idx_q    <= idx_d;
         seen_q   <= seen_d;
         self_q   <= self_d;
         mask_q   <= mask_d;
      end
   end

   // Next-state logic: self check first, then walk each direction until it ends.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      saddr_d  = saddr_q;
      player_d = player_q;
      idx_d    = idx_q;
      seen_d   = seen_q;
      self_d   = self_q;
      mask_d   = mask_q;
      end_dir  = 1'b0;
      own      = player_q ? CellWhite : CellBlack;
      opp      = player_q ? CellBlack : CellWhite;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               saddr_d  = s_addr_in;
               player_d = player;
               ptr_d    = s_addr_in;
               mask_d   = '0;
               idx_d    = '0;
               seen_d   = 1'b0;
               self_d   = 1'b1;
               state_d  = StIssue;
            end
         end

         StIssue: state_d = StCheck;

         StCheck: begin
            if (self_q) begin
               // Occupied or wall candidate: no move, mask stays clear.
               if (rd_data != CellEmpty) begin
                  state_d = StDone;
               end else begin
                  self_d  = 1'b0;
                  ptr_d   = saddr_q + dir_offset(BOARD_W, 3'd0);
                  state_d = StIssue;
               end
            end else begin
               if (rd_data == opp) begin
                  seen_d  = 1'b1;
                  ptr_d   = ptr_q + dir_offset(BOARD_W, idx_q);
                  state_d = StIssue;
               end else begin
                  if ((rd_data == own) && seen_q) begin
                     mask_d[idx_q] = 1'b1;
                  end
                  end_dir = 1'b1;
               end

               // Direction finished: move to the next one (no early exit).
               if (end_dir) begin
                  seen_d = 1'b0;
                  idx_d  = idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     state_d = StDone;
                  end else begin
                     ptr_d   = saddr_q + dir_offset(BOARD_W, idx_q + 3'd1);
                     state_d = StIssue;
                  end
               end
            end
         end

         StDone: state_d = StIdle;

         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state; address only driven while a read is in flight.
   always_comb begin
      busy     = (state_q == StIssue) || (state_q == StCheck);
      done     = (state_q == StDone);
      rd_addr  = busy ? ptr_q : '0;
      dir_mask = mask_q;
      mv_valid = |mask_q;
   end

endmodule

// File: tb/tb_move_validator.sv
// Scoreboard bench for move_validator with a 1-cycle-latency walled board model.
module tb_move_validator;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [6:0] s_addr_in = '0;
   logic       player = 1'b0;
   logic [6:0] rd_addr;
   logic [1:0] rd_data = 2'b00;
   logic       busy, done, mv_valid;
   logic [7:0] dir_mask;

   move_validator #(.BOARD_W(10)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .s_addr_in (s_addr_in),
      .player    (player),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .mv_valid  (mv_valid),
      .dir_mask  (dir_mask)
   );

   always #5 clock = ~clock;

   // Rising-edge counter, only read on falling edges.
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Board memory: 1-cycle read latency, out-of-board addresses read as wall.
   logic [1:0] board [128];
   always @(posedge clock) rd_data <= board[rd_addr];

   typedef struct {
      string      name;
      logic [7:0] mask;
      int         cyc;
   } exp_t;
   exp_t sb [$];

   int n_pass  = 0;
   int n_total = 0;

   function automatic void chk(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endfunction

   task automatic init_board();
      for (int a = 0; a < 128; a++) begin
         if (a >= 100 || (a / 10) == 0 || (a / 10) == 9 || (a % 10) == 0 || (a % 10) == 9)
            board[a] = 2'b11;
         else
            board[a] = 2'b00;
      end
      board[44] = 2'b10;
      board[55] = 2'b10;
      board[45] = 2'b01;
      board[54] = 2'b01;
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", done, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_mask"}, dir_mask, e.mask);
            chk({e.name, "_mv_valid"}, mv_valid, (e.mask != 8'h00) ? 1 : 0);
            chk({e.name, "_done_cycle"}, cyc, e.cyc);
            chk({e.name, "_busy_at_done"}, busy, 0);
            chk({e.name, "_rd_addr_at_done"}, rd_addr, 0);
         end
      end
   end

   // Issue one start from IDLE; done lands in cycle 2R+1 counting the one after the sampling edge.
   task automatic issue(input string name, input logic [6:0] addr, input logic pl,
                        input logic [7:0] mask, input int reads);
      exp_t e;
      @(negedge clock);
      s_addr_in = addr;
      player    = pl;
      start     = 1'b1;
      e.name = name;
      e.mask = mask;
      e.cyc  = cyc + 1 + 2 * reads;
      sb.push_back(e);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!done) begin
         chk({name, "_timeout"}, done, 1);
         sb.delete();
      end
   endtask

   task automatic run(input string name, input logic [6:0] addr, input logic pl,
                      input logic [7:0] mask, input int reads);
      issue(name, addr, pl, mask, reads);
      wait_done(name);
   endtask

   initial begin
      init_board();
      #3;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_mv_valid", mv_valid, 0);
      chk("reset_dir_mask", dir_mask, 0);
      chk("reset_rd_addr", rd_addr, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      run("sq34_black", 7'd34, 1'b0, 8'h40, 10);
      run("sq44_occupied", 7'd44, 1'b0, 8'h00, 1);
      run("sq10_wall", 7'd10, 1'b0, 8'h00, 1);
      run("sq33_black", 7'd33, 1'b0, 8'h00, 11);
      run("sq35_white", 7'd35, 1'b1, 8'h40, 10);

      // Start pulsed mid-scan and again during DONE must both be ignored.
      issue("sq34_ignore", 7'd34, 1'b0, 8'h40, 10);
      repeat (3) @(negedge clock);
      s_addr_in = 7'd44;
      player    = 1'b1;
      start     = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done("sq34_ignore");
      s_addr_in = 7'd33;
      start     = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("start_in_done_busy", busy, 0);
      @(negedge clock);
      chk("start_in_done_busy2", busy, 0);
      chk("hold_dir_mask", dir_mask, 8'h40);
      chk("hold_mv_valid", mv_valid, 1);

      // Reset mid-scan: no expectation queued, so any done is flagged as spurious.
      @(negedge clock);
      s_addr_in = 7'd34;
      player    = 1'b0;
      start     = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("midreset_busy", busy, 0);
      chk("midreset_done", done, 0);
      chk("midreset_mv_valid", mv_valid, 0);
      chk("midreset_dir_mask", dir_mask, 0);
      chk("midreset_rd_addr", rd_addr, 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (25) @(negedge clock);
      chk("after_reset_idle_busy", busy, 0);
      run("sq34_after_reset", 7'd34, 1'b0, 8'h40, 10);

      // Long +1 run across row 1.
      for (int a = 12; a <= 17; a++) board[a] = 2'b10;
      board[18] = 2'b01;
      run("sq11_row_run", 7'd11, 1'b0, 8'h10, 15);

      repeat (3) @(negedge clock);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
